// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory controller slice.
//   mem_state_t : access sequencer states
//   WORD_W      : data/address width of the processor bus
//   REG_RST     : reset value of MAR and MDR
//   CNT_W       : width of the strobe wait counter (covers WAIT_CYCLES 1..15)
package lc3_mem_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [15:0] REG_RST = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for the SRAM strobe window.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clear    : force the count to zero
//   enable   : advance the count by one
//   terminal : high while enabled and the count sits on the last strobe cycle
module mem_wait_counter
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: MAR/MDR registers and the asynchronous SRAM handshake.
//   Clk, Reset          : clock, synchronous active-high reset
//   DataBus             : shared processor bus, source for MAR/MDR loads
//   LD_MAR, LD_MDR      : register load strobes (honoured only when idle)
//   mem_rd, mem_wr      : access requests (sampled only when idle, read wins)
//   mem_rdata           : SRAM read data, captured into MDR at end of read
//   MAR, MDR            : address / data registers (MDR feeds MDR_bus)
//   mem_addr, mem_wdata : SRAM address and write data (copies of MAR / MDR)
//   CE_N, OE_N, WE_N    : registered active-low SRAM strobes
//   ready               : one-cycle completion pulse
//   busy                : high whenever an access is in progress
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int WORD_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] DataBus,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] MAR,
  output logic [WORD_W-1:0] MDR,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              ready,
  output logic              busy
);

  mem_state_t state;
  mem_state_t state_nxt;
  logic       in_wait;
  logic       term;

  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);

  mem_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .terminal(term)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_rd) begin
          state_nxt = RD_WAIT;
        end else if (mem_wr) begin
          state_nxt = WR_WAIT;
        end
      end
      RD_WAIT: if (term) state_nxt = DONE;
      WR_WAIT: if (term) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and ready are flops loaded from the next state, so they line up
  // exactly with the state register and never glitch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CE_N  <= 1'b1;
      OE_N  <= 1'b1;
      WE_N  <= 1'b1;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      CE_N  <= !((state_nxt == RD_WAIT) || (state_nxt == WR_WAIT));
      OE_N  <= !(state_nxt == RD_WAIT);
      WE_N  <= !(state_nxt == WR_WAIT);
      ready <= (state_nxt == DONE);
      busy  <= (state_nxt != IDLE);
    end
  end

  // Loads only land while idle, on the same edge a request is accepted, so the
  // access that starts uses the freshly loaded address/data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      MAR <= WORD_W'(REG_RST);
      MDR <= WORD_W'(REG_RST);
    end else if (state == IDLE) begin
      if (LD_MAR) MAR <= DataBus;
      if (LD_MDR) MDR <= DataBus;
    end else if ((state == RD_WAIT) && term) begin
      MDR <= mem_rdata;
    end
  end

  assign mem_addr  = MAR;
  assign mem_wdata = MDR;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: a transaction-schedule model predicts
// every output each cycle, directed scenarios pin literal values, and a long
// randomized phase exercises loads, requests and resets.
module tb_lc3_mem_ctrl;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] DataBus;
  logic        LD_MAR, LD_MDR, mem_rd, mem_wr;
  logic [15:0] mem_rdata;
  logic [15:0] MAR, MDR, mem_addr, mem_wdata;
  logic        CE_N, OE_N, WE_N, ready, busy;

  lc3_mem_ctrl #(.WAIT_CYCLES(W), .WORD_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .DataBus(DataBus), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .MAR(MAR), .MDR(MDR), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .ready(ready), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: expected output pattern for each upcoming cycle of an access.
  typedef struct packed {
    logic busy;
    logic ce;
    logic oe;
    logic we;
    logic rdy;
    logic cap;
  } ent_t;

  localparam ent_t IDLE_E = '{busy: 1'b0, ce: 1'b1, oe: 1'b1, we: 1'b1, rdy: 1'b0, cap: 1'b0};

  ent_t        sched[$];
  ent_t        cur = IDLE_E;
  logic [15:0] m_mar = 16'h0, m_mdr = 16'h0;
  bit          model_valid = 0;

  initial forever begin
    @(posedge Clk);
    if (Reset === 1'b1) begin
      sched.delete();
      cur = IDLE_E;
      m_mar = 16'h0;
      m_mdr = 16'h0;
      model_valid = 1;
    end else if (model_valid) begin
      if (!cur.busy) begin
        if (LD_MAR) m_mar = DataBus;
        if (LD_MDR) m_mdr = DataBus;
        if (mem_rd || mem_wr) begin
          for (int i = 0; i < W; i++)
            sched.push_back('{busy: 1'b1, ce: 1'b0, oe: !mem_rd, we: mem_rd,
                              rdy: 1'b0, cap: (mem_rd && i == W - 1)});
          sched.push_back('{busy: 1'b1, ce: 1'b1, oe: 1'b1, we: 1'b1, rdy: 1'b1, cap: 1'b0});
        end
      end else if (cur.cap) begin
        m_mdr = mem_rdata;
      end
      cur = (sched.size() > 0) ? sched.pop_front() : IDLE_E;
    end
  end

  initial forever begin
    @(posedge Clk);
    #1;
    if (model_valid) begin
      chk("MAR", MAR, m_mar);
      chk("MDR", MDR, m_mdr);
      chk("mem_addr", mem_addr, m_mar);
      chk("mem_wdata", mem_wdata, m_mdr);
      chk("CE_N", {15'b0, CE_N}, {15'b0, cur.ce});
      chk("OE_N", {15'b0, OE_N}, {15'b0, cur.oe});
      chk("WE_N", {15'b0, WE_N}, {15'b0, cur.we});
      chk("ready", {15'b0, ready}, {15'b0, cur.rdy});
      chk("busy", {15'b0, busy}, {15'b0, cur.busy});
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // Sample n cycles starting with the current one (first cycle after the request edge).
  task automatic observe(input int n, input logic [15:0] wd,
                         output int ce_c, output int oe_c, output int we_c, output int rdy_at,
                         output logic [15:0] mdr_r, output logic [15:0] addr_r,
                         output logic we_r, output int wd_bad);
    ce_c = 0; oe_c = 0; we_c = 0; rdy_at = 0; wd_bad = 0;
    mdr_r = 16'hxxxx; addr_r = 16'hxxxx; we_r = 1'bx;
    for (int k = 1; k <= n; k++) begin
      if (!CE_N) ce_c++;
      if (!OE_N) oe_c++;
      if (!WE_N) we_c++;
      if (!WE_N && mem_wdata !== wd) wd_bad++;
      if (ready && rdy_at == 0) begin
        rdy_at = k; mdr_r = MDR; addr_r = mem_addr; we_r = WE_N;
      end
      step();
    end
  endtask

  int          ce_c, oe_c, we_c, rdy_at, wd_bad;
  logic [15:0] mdr_r, addr_r;
  logic        we_r;

  initial begin
    Reset = 1'b1; DataBus = 16'hFFFF; LD_MAR = 1'b1; LD_MDR = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_rdata = 16'h0;
    step(); step();
    chk("rst_MAR", MAR, 16'h0000);
    chk("rst_MDR", MDR, 16'h0000);
    chk("rst_strobes", {13'b0, CE_N, OE_N, WE_N}, 16'h0007);
    chk("rst_ready_busy", {14'b0, ready, busy}, 16'h0000);
    Reset = 1'b0; LD_MAR = 1'b0;
    step();

    // Read
    DataBus = 16'h3000; LD_MAR = 1'b1; step();
    LD_MAR = 1'b0; mem_rd = 1'b1; mem_rdata = 16'hBEEF; step();
    mem_rd = 1'b0;
    observe(6, 16'h0000, ce_c, oe_c, we_c, rdy_at, mdr_r, addr_r, we_r, wd_bad);
    chk("rd_ce_cycles", 16'(ce_c), 16'd2);
    chk("rd_oe_cycles", 16'(oe_c), 16'd2);
    chk("rd_we_cycles", 16'(we_c), 16'd0);
    chk("rd_ready_cycle", 16'(rdy_at), 16'd3);
    chk("rd_mdr", mdr_r, 16'hBEEF);
    chk("rd_addr", addr_r, 16'h3000);

    // Write
    DataBus = 16'h0042; LD_MAR = 1'b1; step();
    LD_MAR = 1'b0; DataBus = 16'h1234; LD_MDR = 1'b1; step();
    LD_MDR = 1'b0; mem_wr = 1'b1; mem_rdata = 16'hDEAD; step();
    mem_wr = 1'b0;
    observe(6, 16'h1234, ce_c, oe_c, we_c, rdy_at, mdr_r, addr_r, we_r, wd_bad);
    chk("wr_we_cycles", 16'(we_c), 16'd2);
    chk("wr_oe_cycles", 16'(oe_c), 16'd0);
    chk("wr_ready_cycle", 16'(rdy_at), 16'd3);
    chk("wr_we_high_done", {15'b0, we_r}, 16'd1);
    chk("wr_wdata_held", 16'(wd_bad), 16'd0);
    chk("wr_mdr_kept", mdr_r, 16'h1234);
    chk("wr_addr", addr_r, 16'h0042);

    // Priority: read wins
    mem_rd = 1'b1; mem_wr = 1'b1; mem_rdata = 16'hA5A5; step();
    mem_rd = 1'b0; mem_wr = 1'b0;
    observe(6, 16'h0000, ce_c, oe_c, we_c, rdy_at, mdr_r, addr_r, we_r, wd_bad);
    chk("pri_oe_cycles", 16'(oe_c), 16'd2);
    chk("pri_we_cycles", 16'(we_c), 16'd0);
    chk("pri_mdr", mdr_r, 16'hA5A5);

    // Busy lockout
    DataBus = 16'h1111; LD_MAR = 1'b1; step();
    LD_MAR = 1'b0; mem_rd = 1'b1; step();
    mem_rd = 1'b0; LD_MAR = 1'b1; DataBus = 16'h5555;
    chk("lock_busy_k1", {15'b0, busy}, 16'd1);
    step();
    chk("lock_mar_k2", MAR, 16'h1111);
    chk("lock_busy_k2", {15'b0, busy}, 16'd1);
    LD_MAR = 1'b0; step();
    chk("lock_mar_done", MAR, 16'h1111);
    chk("lock_ready_done", {15'b0, ready}, 16'd1);
    step();
    chk("lock_busy_idle", {15'b0, busy}, 16'd0);

    // Reset during the first read wait cycle
    mem_rdata = 16'h7777; mem_rd = 1'b1; step();
    mem_rd = 1'b0;
    chk("mid_oe_active", {15'b0, OE_N}, 16'd0);
    Reset = 1'b1; step();
    chk("mid_strobes", {13'b0, CE_N, OE_N, WE_N}, 16'h0007);
    chk("mid_busy", {15'b0, busy}, 16'd0);
    chk("mid_mdr", MDR, 16'h0000);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_ready", {15'b0, ready}, 16'd0);
      step();
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      DataBus   = 16'($urandom);
      LD_MAR    = ($urandom_range(0, 3) == 0);
      LD_MDR    = ($urandom_range(0, 3) == 0);
      mem_rd    = ($urandom_range(0, 5) == 0);
      mem_wr    = ($urandom_range(0, 5) == 0);
      mem_rdata = 16'($urandom);
      step();
    end
    Reset = 1'b0; LD_MAR = 1'b0; LD_MDR = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Downstream consumer of the shared 16-bit DataBus: holds the MAR and MDR registers and runs the handshake to the external asynchronous SRAM.
- MDR output drives the MDR_bus input of the bus mux. MAR output drives the SRAM address.
- A small FSM sequences read and write strobes over a fixed number of wait cycles.
- A one-cycle ready pulse tells the control FSM when the access is done.

Parameters:
- WAIT_CYCLES, 2, number of cycles the SRAM strobes are held before capture or completion; legal range 1..15.
- WORD_W, 16, data and address width.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- DataBus  in  16  shared processor bus.
- LD_MAR  in  1  load MAR from DataBus.
- LD_MDR  in  1  load MDR from DataBus.
- mem_rd  in  1  request SRAM read into MDR.
- mem_wr  in  1  request SRAM write of MDR to address MAR.
- mem_rdata  in  16  SRAM read data.
- MAR  out  16  memory address register.
- MDR  out  16  memory data register; feeds MDR_bus.
- mem_addr  out  16  SRAM address; always equal to MAR.
- mem_wdata  out  16  SRAM write data; always equal to MDR.
- CE_N  out  1  SRAM chip enable, active low.
- OE_N  out  1  SRAM output enable, active low.
- WE_N  out  1  SRAM write enable, active low.
- ready  out  1  one-cycle pulse: access complete.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset state and values: state IDLE, MAR=0, MDR=0, CE_N=OE_N=WE_N=1, ready=0, busy=0, wait counter=0.
- Reset mid-access: on the next edge everything returns to reset values and strobes deassert. No partial MDR update.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, register loads:
  - LD_MAR=1 → MAR<=DataBus.
  - LD_MDR=1 → MDR<=DataBus.
  - Both may load on the same edge.
- IDLE, requests: mem_rd and mem_wr are sampled only in IDLE.
  - mem_rd=1 → RD_WAIT, counter<=0.
  - Else mem_wr=1 → WR_WAIT, counter<=0.
  - Both high: read wins (fixed priority); the write is dropped.
  - A load and a request in the same IDLE cycle are allowed. The load happens on that same edge, so the access uses the newly loaded MAR/MDR.
- RD_WAIT:
  - Strobes: CE_N=0, OE_N=0, WE_N=1.
  - Counter increments each edge.
  - On the edge where counter==WAIT_CYCLES-1: MDR<=mem_rdata, go DONE.
- WR_WAIT:
  - Strobes: CE_N=0, WE_N=0, OE_N=1.
  - Same counting rule; on the terminal edge go DONE. MDR is not modified.
- DONE:
  - Strobes: all 1 (WE_N rises while address/data still held, giving hold time).
  - ready=1 for exactly this cycle.
  - Next edge → IDLE unconditionally.
- Latency: request sampled at edge E.
  - Strobes are active for exactly WAIT_CYCLES cycles after E.
  - ready=1 in cycle E+WAIT_CYCLES+1.
  - For reads, MDR holds the captured data from that same cycle.
- Busy behaviour:
  - LD_MAR, LD_MDR, mem_rd and mem_wr are ignored while busy.
  - Requests still held high in DONE start a new access once back in IDLE. The control FSM must drop them on ready.
- Strobe timing: all strobes and ready are registered (decoded from registered state), so they are glitch-free.
- Counter: 4 bits wide; it never wraps for legal WAIT_CYCLES. WAIT_CYCLES=1 gives a single strobe cycle.
- Output mapping: mem_addr and mem_wdata are continuous assigns of MAR and MDR.

Decomposition:
- Package lc3_mem_pkg holds:
  - state enum mem_state_t {IDLE, RD_WAIT, WR_WAIT, DONE};
  - WORD_W=16;
  - reset constant for MAR/MDR (16'h0000).
- One sub-module: mem_wait_counter (clear, enable, terminal-count output, parameter WAIT_CYCLES).
- MAR/MDR registers and the FSM stay in lc3_mem_ctrl.

Test Plan:
- Reset: Reset=1 for 2 cycles with DataBus=16'hFFFF, LD_MAR=1 → MAR=0, MDR=0, CE_N=OE_N=WE_N=1, ready=0, busy=0.
- Read: DataBus=16'h3000 with LD_MAR, then mem_rd with mem_rdata=16'hBEEF, WAIT_CYCLES=2 → CE_N/OE_N low exactly 2 cycles; ready high 3 cycles after the request edge; MDR=16'hBEEF; mem_addr=16'h3000.
- Write: MAR=16'h0042, MDR=16'h1234 via DataBus, then mem_wr → WE_N low 2 cycles, mem_wdata=16'h1234 throughout, WE_N high in the DONE cycle, ready pulse, MDR unchanged.
- Priority: mem_rd=mem_wr=1 in IDLE → read sequence only (OE_N low, WE_N never low).
- Busy lockout: during RD_WAIT drive LD_MAR=1, DataBus=16'h5555 → MAR unchanged; busy=1 until IDLE.
- Reset mid-read: Reset during the first RD_WAIT cycle → next cycle strobes high, state IDLE, MDR=0, no ready pulse.
